// File: rtl/csr_test_pkg.sv
// rtl/csr_test_pkg.sv - shared constants for the CSR tohost test monitor
package csr_test_pkg;

  // Status / state encoding, also driven directly on the status port
  localparam logic [2:0] ST_HOLDOFF = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  // Address of the tohost CSR that software writes its verdict to
  localparam logic [11:0] CSR_TOHOST = 12'h51E;

  // True for the three states in which the run has been judged
  function automatic logic is_terminal(input logic [2:0] st);
    return (st == ST_PASS) || (st == ST_FAIL) || (st == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear wins over increment; once all-ones the value is held rather than wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/csr_test_monitor.sv
// rtl/csr_test_monitor.sv - classifies a test run as PASS/FAIL/TIMEOUT from tohost writes
module csr_test_monitor
  import csr_test_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4_000_000,
  parameter int unsigned START_DELAY    = 10,
  parameter logic [31:0] PASS_CODE      = 32'h1,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csr_we,
  input  logic [11:0]          csr_addr,
  input  logic [31:0]          csr_wdata,
  input  logic                 instr_retire,
  input  logic                 clear,
  output logic [2:0]           status,
  output logic                 done,
  output logic                 done_pulse,
  output logic [31:0]          result,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retire_count
);

  // Holdoff counter only needs to reach START_DELAY-1
  localparam int unsigned HW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic          valid_wr;
  logic          is_pass;
  logic          timeout_hit;
  logic          done_d;
  logic          pulse_d;

  assign hold_done = (hold_cnt == HW'(START_DELAY - 1));
  assign valid_wr  = csr_we && (csr_addr == CSR_TOHOST) && (csr_wdata != 32'd0);
  assign is_pass   = (csr_wdata == PASS_CODE);
  // Compared in 64 bits so a narrowed counter saturates instead of aliasing the limit
  assign timeout_hit = (64'(cycle_count) == 64'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HOLDOFF;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: clear overrides everything, a valid write beats the timeout
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = ST_HOLDOFF;
    end else begin
      case (state)
        ST_HOLDOFF: if (hold_done) next_state = ST_RUN;
        ST_RUN: begin
          if (valid_wr) begin
            next_state = is_pass ? ST_PASS : ST_FAIL;
          end else if (timeout_hit) begin
            next_state = ST_TIMEOUT;
          end
        end
        ST_PASS, ST_FAIL, ST_TIMEOUT: next_state = state;
        default: next_state = ST_HOLDOFF;
      endcase
    end
  end

  // Output decode from the upcoming state so done/done_pulse register alongside it
  always_comb begin
    done_d  = is_terminal(next_state);
    pulse_d = is_terminal(next_state) && !is_terminal(state);
  end

  // Registered flags and the latched tohost value
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      done       <= 1'b0;
      done_pulse <= 1'b0;
      result     <= 32'd0;
    end else begin
      done       <= done_d;
      done_pulse <= pulse_d;
      if ((state == ST_RUN) && valid_wr) begin
        result <= csr_wdata;
      end
    end
  end

  // Holdoff delay counter, restarted whenever we are not in HOLDOFF
  always_ff @(posedge clk) begin
    if (rst || clear || (state != ST_HOLDOFF)) begin
      hold_cnt <= '0;
    end else if (!hold_done) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  assign status = state;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (state == ST_RUN),
    .count (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   ((state == ST_RUN) && instr_retire),
    .count (retire_count)
  );

endmodule

// File: tb/tb_csr_test_monitor.sv
// tb/tb_csr_test_monitor.sv - self-checking bench for csr_test_monitor
module tb_csr_test_monitor;

  localparam int TO = 100;
  localparam int SD = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        instr_retire;
  logic        clear;

  logic [2:0]  status;
  logic        done;
  logic        done_pulse;
  logic [31:0] result;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  logic [2:0]  s_status;
  logic        s_done;
  logic        s_done_pulse;
  logic [31:0] s_result;
  logic [3:0]  s_cycle_count;
  logic [3:0]  s_retire_count;

  int n_vec = 0;
  int n_bad = 0;

  // reference model
  int          m_status, m_hold, m_cyc, m_ret;
  logic [31:0] m_res;
  logic        m_done, m_pulse;

  always #5 clk = ~clk;

  csr_test_monitor #(.TIMEOUT_CYCLES(TO), .START_DELAY(SD), .PASS_CODE(32'h1), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .instr_retire(instr_retire), .clear(clear), .status(status), .done(done),
    .done_pulse(done_pulse), .result(result), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  csr_test_monitor #(.TIMEOUT_CYCLES(TO), .START_DELAY(SD), .PASS_CODE(32'h1), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .instr_retire(instr_retire), .clear(clear), .status(s_status), .done(s_done),
    .done_pulse(s_done_pulse), .result(s_result), .cycle_count(s_cycle_count), .retire_count(s_retire_count)
  );

  task automatic model_zero();
    m_status = 0; m_hold = 0; m_cyc = 0; m_ret = 0; m_res = 32'd0; m_done = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic step(input logic we, input logic [11:0] a, input logic [31:0] d,
                      input logic rt, input logic cl, input logic r);
    rst = r; csr_we = we; csr_addr = a; csr_wdata = d; instr_retire = rt; clear = cl;
    if (r || cl) begin
      model_zero();
    end else begin
      m_pulse = 1'b0;
      if (m_status == 0) begin
        m_hold++;
        if (m_hold == SD) m_status = 1;
      end else if (m_status == 1) begin
        m_cyc++;
        if (rt) m_ret++;
        if (we && a == 12'h51E && d != 0) begin
          m_status = (d == 1) ? 2 : 3; m_res = d; m_done = 1'b1; m_pulse = 1'b1;
        end else if (m_cyc == TO) begin
          m_status = 4; m_done = 1'b1; m_pulse = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait_run(input string tag);
    int waited = 0;
    while (status !== 3'd1 && waited < 30) begin
      idle(1);
      waited++;
    end
    n_vec++;
    if (waited != SD) begin
      n_bad++;
      $display("FAIL %s_holdoff_len got %0d cycles want %0d (status %0d)", tag, waited, SD, status);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({status, done, done_pulse} !== 5'd0) begin
      n_bad++; $display("FAIL reset_flags got %b want 0", {status, done, done_pulse});
    end
    n_vec++;
    if ({result, cycle_count, retire_count} !== 96'd0) begin
      n_bad++; $display("FAIL reset_values got %h want 0", {result, cycle_count, retire_count});
    end
  endtask

  task automatic test_pass();
    int pulses;
    do_reset();
    wait_run("pass");
    idle(4);
    step(1'b1, 12'h51E, 32'h1, 1'b0, 1'b0, 1'b0);
    pulses = done_pulse ? 1 : 0;
    n_vec++;
    if ({status, result, cycle_count, done} !== {3'd2, 32'd1, 32'd5, 1'b1}) begin
      n_bad++; $display("FAIL pass_outputs got st=%0d res=%0d cyc=%0d done=%b want 2 1 5 1", status, result, cycle_count, done);
    end
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (done_pulse) pulses++;
    end
    n_vec++;
    if (pulses != 1) begin
      n_bad++; $display("FAIL pass_pulse_count got %0d want 1", pulses);
    end
    n_vec++;
    if ({status, done, cycle_count} !== {3'd2, 1'b1, 32'd5}) begin
      n_bad++; $display("FAIL pass_hold got st=%0d done=%b cyc=%0d want 2 1 5", status, done, cycle_count);
    end
  endtask

  task automatic test_fail();
    do_reset();
    wait_run("fail");
    for (int i = 0; i < int'($urandom_range(1, 20)); i++)
      step(1'b0, 12'h0, 32'h0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b1, 12'h51E, 32'h7, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({status, result, cycle_count, retire_count} !== {3'(m_status), m_res, 32'(m_cyc), 32'(m_ret)} || status !== 3'd3 || result !== 32'd7) begin
      n_bad++; $display("FAIL fail_outputs got st=%0d res=%0d cyc=%0d ret=%0d want 3 7 %0d %0d", status, result, cycle_count, retire_count, m_cyc, m_ret);
    end
    step(1'b1, 12'h51E, 32'h1, 1'b1, 1'b0, 1'b0);
    idle(2);
    n_vec++;
    if ({status, result} !== {3'd3, 32'd7}) begin
      n_bad++; $display("FAIL fail_sticky got st=%0d res=%0d want 3 7", status, result);
    end
  endtask

  task automatic test_timeout();
    int k = 0;
    int pulses = 0;
    logic [11:0] a;
    logic [31:0] d;
    do_reset();
    wait_run("timeout");
    while (status === 3'd1 && k < 150) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 12'h51E; d = 32'h0;
      end else begin
        a = 12'($urandom); if (a == 12'h51E) a = 12'h340; d = $urandom;
      end
      step(1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (done_pulse) pulses++;
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (done_pulse) pulses++;
    end
    n_vec++;
    if (k != TO || status !== 3'd4) begin
      n_bad++; $display("FAIL timeout_when got %0d cycles st=%0d want %0d st=4", k, status, TO);
    end
    n_vec++;
    if ({cycle_count, result, retire_count} !== {32'd100, 32'd0, 32'(m_ret)}) begin
      n_bad++; $display("FAIL timeout_values got cyc=%0d res=%0d ret=%0d want 100 0 %0d", cycle_count, result, retire_count, m_ret);
    end
    n_vec++;
    if (pulses != 1 || done !== 1'b1) begin
      n_bad++; $display("FAIL timeout_pulse got pulses=%0d done=%b want 1 1", pulses, done);
    end
  endtask

  task automatic test_filter();
    do_reset();
    wait_run("filter");
    step(1'b1, 12'h51E, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h340, 32'h1, 1'b0, 1'b0, 1'b0);
    idle(1);
    n_vec++;
    if ({status, result, done} !== {3'd1, 32'd0, 1'b0}) begin
      n_bad++; $display("FAIL filter_ignored got st=%0d res=%0d done=%b want 1 0 0", status, result, done);
    end
    step(1'b1, 12'h51E, 32'h1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (status !== 3'd2) begin
      n_bad++; $display("FAIL filter_then_pass got st=%0d want 2", status);
    end
    do_reset();
    for (int i = 0; i < SD; i++) step(1'b1, 12'h51E, 32'h1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({status, result, cycle_count, retire_count} !== {3'd1, 32'd0, 32'd0, 32'd0}) begin
      n_bad++; $display("FAIL holdoff_ignore got st=%0d res=%0d cyc=%0d ret=%0d want 1 0 0 0", status, result, cycle_count, retire_count);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    wait_run("boundary");
    idle(TO - 1);
    n_vec++;
    if ({status, cycle_count} !== {3'd1, 32'd99}) begin
      n_bad++; $display("FAIL boundary_pre got st=%0d cyc=%0d want 1 99", status, cycle_count);
    end
    step(1'b1, 12'h51E, 32'h1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({status, cycle_count, done_pulse} !== {3'd2, 32'd100, 1'b1}) begin
      n_bad++; $display("FAIL boundary_write_wins got st=%0d cyc=%0d pulse=%b want 2 100 1", status, cycle_count, done_pulse);
    end
    do_reset();
    wait_run("clear_write");
    idle(3);
    step(1'b1, 12'h51E, 32'h1, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({status, done, done_pulse, result, cycle_count} !== {3'd0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      n_bad++; $display("FAIL clear_beats_write got st=%0d done=%b pulse=%b res=%0d cyc=%0d want all 0", status, done, done_pulse, result, cycle_count);
    end
  endtask

  task automatic test_counting();
    do_reset();
    wait_run("count");
    for (int i = 0; i < 3; i++) step(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 12'h51E, 32'h1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({status, retire_count} !== {3'd2, 32'd3}) begin
      n_bad++; $display("FAIL retire_three got st=%0d ret=%0d want 2 3", status, retire_count);
    end
    step(1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({status, done, done_pulse, result, cycle_count, retire_count} !== 101'd0) begin
      n_bad++; $display("FAIL clear_in_pass got st=%0d done=%b res=%0d cyc=%0d ret=%0d want all 0", status, done, result, cycle_count, retire_count);
    end
    wait_run("recount");
    for (int i = 0; i < 20; i++) step(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if ({retire_count, s_retire_count, s_cycle_count} !== {32'd20, 4'd15, 4'd15}) begin
      n_bad++; $display("FAIL retire_saturate got ret=%0d small_ret=%0d small_cyc=%0d want 20 15 15", retire_count, s_retire_count, s_cycle_count);
    end
    step(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if ({status, done, done_pulse, result, cycle_count, retire_count, s_status, s_done, s_done_pulse, s_result, s_cycle_count, s_retire_count} !== 210'd0) begin
      n_bad++; $display("FAIL rst_mid_run got st=%0d cyc=%0d ret=%0d small_st=%0d small_ret=%0d want all 0", status, cycle_count, retire_count, s_status, s_retire_count);
    end
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [31:0] d;
    int sel;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        sel = $urandom_range(0, 2);
        a = (sel == 0) ? 12'h51E : (sel == 1) ? 12'h340 : 12'($urandom);
        sel = $urandom_range(0, 2);
        d = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h1 : $urandom;
        step($urandom_range(0, 99) < 8, a, d, 1'($urandom_range(0, 1)),
             $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
        n_vec++;
        if ({status, done, done_pulse, result, cycle_count, retire_count} !==
            {3'(m_status), m_done, m_pulse, m_res, 32'(m_cyc), 32'(m_ret)}) begin
          n_bad++;
          $display("FAIL random_it%0d_c%0d got st=%0d d=%b p=%b res=%h cyc=%0d ret=%0d want st=%0d d=%b p=%b res=%h cyc=%0d ret=%0d",
                   it, c, status, done, done_pulse, result, cycle_count, retire_count,
                   m_status, m_done, m_pulse, m_res, m_cyc, m_ret);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0; instr_retire = 1'b0; clear = 1'b0;
    model_zero();
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_filter();
    test_boundary();
    test_counting();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_test_monitor.md
Name: csr_test_monitor

Overview:
Synthesizable pass/fail monitor sitting directly downstream of the CPU's CSR write port inside top_axi.
- Watches writes to the tohost CSR (0x51E) and classifies the run as PASS, FAIL or TIMEOUT.
- Latches the written code and reports cycle and retired-instruction counts.
- The same software tests can then be judged on FPGA (LEDs/UART status) as well as in simulation.
- Simulation benches observe `status`/`done_pulse` instead of polling raw csr.

Parameters:
TIMEOUT_CYCLES, 4_000_000, RUN cycles before declaring TIMEOUT (>=2)
START_DELAY, 10, cycles after reset/clear before monitoring starts (>=1)
PASS_CODE, 32'h1, tohost value meaning PASS
CNT_WIDTH, 32, width of cycle/retire counters (>= clog2(TIMEOUT_CYCLES+1))

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
csr_we  in  1  CPU CSR write strobe, one cycle per write
csr_addr  in  12  CSR address of the write
csr_wdata  in  32  CSR write data
instr_retire  in  1  one pulse per retired instruction
clear  in  1  return to HOLDOFF and restart monitoring
status  out  3  0=HOLDOFF 1=RUN 2=PASS 3=FAIL 4=TIMEOUT
done  out  1  high in PASS/FAIL/TIMEOUT
done_pulse  out  1  single-cycle pulse on entry to a terminal state
result  out  32  latched tohost value (0 on TIMEOUT)
cycle_count  out  CNT_WIDTH  RUN cycles elapsed, frozen at terminal
retire_count  out  CNT_WIDTH  retired instructions during RUN, frozen at terminal

Behaviour:
- Reset (rst=1, sampled on clk): state=HOLDOFF; all outputs 0; holdoff counter=0.
- All outputs are registered. `status`/`done` reflect the current state.
- HOLDOFF:
  - Counts START_DELAY cycles, then moves to RUN.
  - CSR writes and instr_retire are ignored; counters stay 0.
- RUN, evaluated each cycle:
  - cycle_count += 1, including the cycle of the terminal event.
  - retire_count += instr_retire.
  - Valid terminal write = csr_we && csr_addr==CSR_TOHOST && csr_wdata!=0.
    - wdata==PASS_CODE: next state PASS.
    - Otherwise: next state FAIL.
    - result <= csr_wdata in both cases.
  - Writes of 0 to tohost and writes to any other address are ignored.
  - No valid write and cycle_count==TIMEOUT_CYCLES-1: next state TIMEOUT; result stays 0.
  - Simultaneous valid write and timeout cycle: the write wins (PASS/FAIL), cycle_count=TIMEOUT_CYCLES.
- Terminal states (PASS/FAIL/TIMEOUT):
  - Hold all outputs; further writes and retires are ignored.
  - done=1. done_pulse=1 only in the first cycle of the state.
  - Latency: a terminal write in cycle N gives status/result/done_pulse valid in cycle N+1.
- clear:
  - Honoured in any state.
  - Next cycle: HOLDOFF, counters/result/done cleared, holdoff counter restarts.
  - rst has priority over clear.
  - clear in the same cycle as a valid write: clear wins, no done_pulse.
- Counters saturate at all-ones and never wrap; relevant when CNT_WIDTH is reduced for tests.
- rst mid-RUN: identical to power-on reset; no done_pulse.

Decomposition:
- Package csr_test_pkg:
  - Status/state encoding constants: ST_HOLDOFF=0, ST_RUN=1, ST_PASS=2, ST_FAIL=3, ST_TIMEOUT=4.
  - CSR_TOHOST=12'h51E.
- Sub-module sat_counter (params WIDTH; ports clk, rst, clr, inc, count):
  - Synchronous clear, saturating increment.
  - Instantiated twice: cycle_count (inc = state==RUN) and retire_count (inc = RUN && instr_retire).
- FSM, holdoff counter and result latch live in csr_test_monitor.

Test Plan:
Bench parameters for all scenarios: TIMEOUT_CYCLES=100, START_DELAY=10.
1. Reset 5 cycles, release, wait 10 cycles; in the 5th RUN cycle write 0x51E=1 → next cycle status=2, result=1, cycle_count=5, done_pulse high exactly 1 cycle, done stays high.
2. Write 0x51E=7 → status=3, result=7. Write 0x51E=1 afterwards → no change.
3. No writes → after 100 RUN cycles status=4, cycle_count=100, result=0, one done_pulse.
4. Filtering:
   - Write 0x51E=0, then 0x340=1, during RUN → status stays 1.
   - Then write 0x51E=1 → status=2.
   - Write 0x51E=1 during HOLDOFF → ignored; status reaches 1 after 10 cycles.
5. Valid write 0x51E=1 exactly on RUN cycle 100 → status=2 (not 4), cycle_count=100. Separately: clear asserted together with a valid write → status=0, no done_pulse.
6. Counting, clear and reset:
   - 3 instr_retire pulses then PASS → retire_count=3.
   - With CNT_WIDTH=4 and 20 pulses → retire_count=15.
   - clear in PASS → HOLDOFF, all outputs 0.
   - rst mid-RUN → all outputs 0.
